// File: rtl/lab5_nios2_qsys_0_oci_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lab5_nios2_qsys_0_oci_pkg
// Description : Shared FSM encoding and default sizing for the DCT monitor.
// Revision    : 1.0
// ============================================================================
package lab5_nios2_qsys_0_oci_pkg;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int C_SLOT_W = 2;
    localparam int C_SLOTS  = 15;
    localparam int C_CNT_W  = 4;
    localparam int C_DEPTH  = 8;

endpackage
`default_nettype wire

// File: rtl/lab5_nios2_qsys_0_oci_dct_fifo.sv
`default_nettype none
// ============================================================================
// Module      : lab5_nios2_qsys_0_oci_dct_fifo
// Description : First-word-fall-through FIFO with flush and occupancy level.
// Revision    : 1.0
// ============================================================================
module lab5_nios2_qsys_0_oci_dct_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH+1)-1:0] o_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_level == '0);
    assign o_full    = (r_level == LVL_W'(DEPTH));
    assign o_level   = r_level;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/lab5_nios2_qsys_0_oci_dct_monitor.sv
`default_nettype none
// ============================================================================
// Module      : lab5_nios2_qsys_0_oci_dct_monitor
// Description : Captures DCT trace words into a FIFO; RUN/DRAIN/DONE control.
// Revision    : 1.0
// ============================================================================
module lab5_nios2_qsys_0_oci_dct_monitor
    import lab5_nios2_qsys_0_oci_pkg::*;
#(
    parameter int SLOT_W = C_SLOT_W,
    parameter int SLOTS  = C_SLOTS,
    parameter int CNT_W  = C_CNT_W,
    parameter int DEPTH  = C_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [SLOT_W*SLOTS-1:0]    dct_buffer,
    input  logic [CNT_W-1:0]           dct_count,
    input  logic                       dct_load,
    input  logic                       test_ending,
    input  logic                       test_has_ended,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [SLOT_W*SLOTS-1:0]    rd_data,
    output logic [CNT_W-1:0]           rd_count,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic                       overflow,
    output logic                       count_err,
    output logic [15:0]                drop_cnt,
    output logic                       done
);

    localparam int              DATA_W      = SLOT_W * SLOTS;
    localparam int              ENTRY_W     = DATA_W + CNT_W;
    localparam logic [CNT_W-1:0] c_SLOTS_CNT = CNT_W'(SLOTS);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic               w_cap_en;
    logic               w_load;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_empty;
    logic               w_full;
    logic [CNT_W-1:0]   w_cnt_clamp;
    logic [ENTRY_W-1:0] w_head;
    logic               r_overflow;
    logic               r_count_err;
    logic [15:0]        r_drop_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (test_has_ended) begin
            w_next_state = ST_DONE;
        end else begin
            case (r_state)
                ST_RUN:   if (test_ending) w_next_state = ST_DRAIN;
                // Leave DRAIN once the FIFO is empty after this cycle's pop.
                ST_DRAIN: if (fifo_level == '0 || (fifo_level == 1 && w_pop))
                              w_next_state = ST_DONE;
                default:  w_next_state = ST_DONE;
            endcase
        end
    end

    always_comb begin
        done     = (r_state == ST_DONE);
        w_cap_en = (r_state == ST_RUN);
        rd_valid = !w_empty && (r_state != ST_DONE);
    end

    assign w_load      = w_cap_en && dct_load && (dct_count != '0) && !test_has_ended;
    assign w_pop       = rd_valid && rd_ready;
    assign w_push      = w_load && (!w_full || w_pop);
    assign w_drop      = w_load && w_full && !w_pop;
    assign w_cnt_clamp = (dct_count > c_SLOTS_CNT) ? c_SLOTS_CNT : dct_count;

    lab5_nios2_qsys_0_oci_dct_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (test_has_ended),
        .i_wdata ({dct_buffer, w_cnt_clamp}),
        .o_rdata (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_level (fifo_level)
    );

    assign rd_data  = w_head[ENTRY_W-1:CNT_W];
    assign rd_count = w_head[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_count_err <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_load && (dct_count > c_SLOTS_CNT)) begin
                r_count_err <= 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 16'hFFFF) begin
                    r_drop_cnt <= r_drop_cnt + 16'd1;
                end
            end
        end
    end

    assign overflow  = r_overflow;
    assign count_err = r_count_err;
    assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lab5_nios2_qsys_0_oci_dct_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_lab5_nios2_qsys_0_oci_dct_monitor
// Description : Directed self-checking bench for the DCT monitor.
// Revision    : 1.0
// ============================================================================
module tb_lab5_nios2_qsys_0_oci_dct_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        dct_load;
    logic        test_ending;
    logic        test_has_ended;
    logic        rd_ready;

    logic        rd_valid;
    logic [29:0] rd_data;
    logic [3:0]  rd_count;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic        count_err;
    logic [15:0] drop_cnt;
    logic        done;

    logic        b_rd_valid;
    logic [23:0] b_rd_data;
    logic [3:0]  b_rd_count;
    logic [3:0]  b_fifo_level;
    logic        b_overflow;
    logic        b_count_err;
    logic [15:0] b_drop_cnt;
    logic        b_done;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    lab5_nios2_qsys_0_oci_dct_monitor u_dut (
        .clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .dct_load(dct_load), .test_ending(test_ending), .test_has_ended(test_has_ended),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .rd_count(rd_count),
        .fifo_level(fifo_level), .overflow(overflow), .count_err(count_err),
        .drop_cnt(drop_cnt), .done(done)
    );

    lab5_nios2_qsys_0_oci_dct_monitor #(.SLOTS(12), .CNT_W(4)) u_dut12 (
        .clk(clk), .reset(reset), .dct_buffer(dct_buffer[23:0]), .dct_count(dct_count),
        .dct_load(dct_load), .test_ending(test_ending), .test_has_ended(test_has_ended),
        .rd_ready(rd_ready), .rd_valid(b_rd_valid), .rd_data(b_rd_data), .rd_count(b_rd_count),
        .fifo_level(b_fifo_level), .overflow(b_overflow), .count_err(b_count_err),
        .drop_cnt(b_drop_cnt), .done(b_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; dct_load = 1'b0; dct_count = '0; dct_buffer = '0;
        test_ending = 1'b0; test_has_ended = 1'b0; rd_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_rd_valid"},  32'(rd_valid),   32'd0);
        check({pfx, "_rd_data"},   32'(rd_data),    32'd0);
        check({pfx, "_rd_count"},  32'(rd_count),   32'd0);
        check({pfx, "_level"},     32'(fifo_level), 32'd0);
        check({pfx, "_overflow"},  32'(overflow),   32'd0);
        check({pfx, "_count_err"}, 32'(count_err),  32'd0);
        check({pfx, "_drop_cnt"},  32'(drop_cnt),   32'd0);
        check({pfx, "_done"},      32'(done),       32'd0);
    endtask

    initial begin
        do_reset();
        check_reset_outputs("rst");

        // In-order reads, each one cycle after its load
        rd_ready = 1'b1;
        dct_load = 1'b1; dct_count = 4'd5; dct_buffer = 30'h1234567;
        tick();
        check("ord1_valid", 32'(rd_valid), 32'd1);
        check("ord1_data",  32'(rd_data),  32'h1234567);
        check("ord1_count", 32'(rd_count), 32'd5);
        dct_count = 4'd15; dct_buffer = 30'h2AAAAAAA;
        tick();
        check("ord2_data",  32'(rd_data),    32'h2AAAAAAA);
        check("ord2_count", 32'(rd_count),   32'd15);
        check("ord2_level", 32'(fifo_level), 32'd1);
        dct_count = 4'd1; dct_buffer = 30'h0000003;
        tick();
        check("ord3_data",  32'(rd_data),  32'h3);
        check("ord3_count", 32'(rd_count), 32'd1);
        dct_load = 1'b0;
        tick();
        check("ord_empty_valid", 32'(rd_valid),   32'd0);
        check("ord_empty_level", 32'(fifo_level), 32'd0);

        // Overflow: 10 loads into an 8-deep FIFO with no consumer
        do_reset();
        for (int i = 0; i < 10; i++) begin
            dct_load = 1'b1; dct_count = 4'd3; dct_buffer = 30'h100 + 30'(i);
            tick();
        end
        check("ovf_level",    32'(fifo_level), 32'd8);
        check("ovf_flag",     32'(overflow),   32'd1);
        check("ovf_drops",    32'(drop_cnt),   32'd2);
        check("ovf_head",     32'(rd_data),    32'h100);
        rd_ready = 1'b1;
        tick();
        check("full_pp_level", 32'(fifo_level), 32'd8);
        check("full_pp_drops", 32'(drop_cnt),   32'd2);
        check("full_pp_head",  32'(rd_data),    32'h101);
        dct_load = 1'b0; rd_ready = 1'b0;

        // Count clamping on the 12-slot instance; zero-count load ignored
        do_reset();
        dct_load = 1'b1; dct_count = 4'd15; dct_buffer = 30'h0ABCDEF;
        tick();
        dct_count = 4'd0; dct_buffer = 30'h0111111;
        tick();
        dct_load = 1'b0;
        tick();
        check("clamp_level",     32'(b_fifo_level), 32'd1);
        check("clamp_count",     32'(b_rd_count),   32'd12);
        check("clamp_data",      32'(b_rd_data),    32'hABCDEF);
        check("clamp_err",       32'(b_count_err),  32'd1);
        check("noclamp_err_def", 32'(count_err),    32'd0);
        check("noclamp_cnt_def", 32'(rd_count),     32'd15);

        // Drain: 4 queued + 1 loaded with test_ending, later loads ignored
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            dct_load = 1'b1; dct_count = 4'(i); dct_buffer = 30'(i);
            tick();
        end
        dct_count = 4'd5; dct_buffer = 30'd5; test_ending = 1'b1;
        tick();
        test_ending = 1'b0; dct_count = 4'd6; dct_buffer = 30'd6;
        check("drain_level", 32'(fifo_level), 32'd5);
        rd_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("drain_cnt%0d", k), 32'(rd_count), 32'(k));
            check($sformatf("drain_done%0d", k), 32'(done), 32'd0);
            tick();
        end
        check("drain_done",  32'(done),       32'd1);
        check("drain_valid", 32'(rd_valid),   32'd0);
        check("drain_lvl0",  32'(fifo_level), 32'd0);
        tick();
        check("done_hold",   32'(done),       32'd1);
        check("done_noload", 32'(fifo_level), 32'd0);
        dct_load = 1'b0; rd_ready = 1'b0;

        // Abort with ending at the same time flushes immediately
        do_reset();
        for (int i = 0; i < 3; i++) begin
            dct_load = 1'b1; dct_count = 4'd2; dct_buffer = 30'(i);
            tick();
        end
        dct_load = 1'b0;
        check("abort_pre_level", 32'(fifo_level), 32'd3);
        test_ending = 1'b1; test_has_ended = 1'b1;
        tick();
        test_ending = 1'b0; test_has_ended = 1'b0;
        check("abort_done",  32'(done),       32'd1);
        check("abort_valid", 32'(rd_valid),   32'd0);
        check("abort_level", 32'(fifo_level), 32'd0);

        // Reset from DONE with overflow set
        do_reset();
        for (int i = 0; i < 9; i++) begin
            dct_load = 1'b1; dct_count = 4'd1; dct_buffer = 30'(i);
            tick();
        end
        dct_load = 1'b0; test_has_ended = 1'b1;
        tick();
        test_has_ended = 1'b0;
        check("pre_rst_done", 32'(done),     32'd1);
        check("pre_rst_ovf",  32'(overflow), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_outputs("rst2");
        dct_load = 1'b1; dct_count = 4'd7; dct_buffer = 30'h77;
        tick();
        dct_load = 1'b0;
        check("post_rst_valid", 32'(rd_valid), 32'd1);
        check("post_rst_count", 32'(rd_count), 32'd7);
        check("post_rst_data",  32'(rd_data),  32'h77);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lab5_nios2_qsys_0_oci_dct_monitor.md
LAB5_NIOS2_QSYS_0_OCI_DCT_MONITOR -- requirements
Module: lab5_nios2_qsys_0_oci_dct_monitor

Interface
REQ-001 Parameter SLOT_W, default 2, SHALL set the bit width of one trace slot.
REQ-002 Parameter SLOTS, default 15, SHALL set the slots per capture word; dct_buffer width is SLOT_W*SLOTS (30 at defaults).
REQ-003 Parameter CNT_W, default 4, SHALL set the dct_count width and SHALL be at least clog2(SLOTS+1).
REQ-004 Parameter DEPTH, default 8, SHALL set the FIFO depth in entries and SHALL be a power of two, at least 2.
REQ-005 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-006 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-007 dct_buffer  input  SLOT_W*SLOTS  SHALL carry packed trace slots, with slot 0 in the LSBs.
REQ-008 dct_count  input  CNT_W  SHALL give the number of valid slots in dct_buffer.
REQ-009 dct_load  input  1  SHALL be a one-cycle capture strobe.
REQ-010 test_ending  input  1  SHALL be the end-of-test request, sampled each cycle.
REQ-011 test_has_ended  input  1  SHALL be the test-abort indication, sampled each cycle.
REQ-012 rd_ready  input  1  SHALL be the consumer handshake.
REQ-013 rd_valid  output  1  SHALL be high when the FIFO head is valid.
REQ-014 rd_data  output  SLOT_W*SLOTS  SHALL be the FIFO head payload.
REQ-015 rd_count  output  CNT_W  SHALL be the FIFO head slot count.
REQ-016 fifo_level  output  clog2(DEPTH+1)  SHALL be the current occupancy.
REQ-017 overflow  output  1  SHALL be a sticky flag for a dropped capture.
REQ-018 count_err  output  1  SHALL be a sticky flag for dct_count > SLOTS.
REQ-019 drop_cnt  output  16  SHALL count dropped captures, saturating at 16'hFFFF.
REQ-020 done  output  1  SHALL indicate monitor finished.

Function
REQ-021 The FSM SHALL have states RUN, DRAIN and DONE; reset SHALL enter RUN.
REQ-022 Capture condition: in RUN, dct_load=1 and dct_count!=0; dct_load with dct_count=0 SHALL be ignored with no flag.
REQ-023 Accepted capture: {dct_buffer, min(dct_count,SLOTS)} SHALL be written; if dct_count>SLOTS, count_err SHALL set.
REQ-024 Pop: rd_valid & rd_ready SHALL remove the head; FIFO SHALL be first-word-fall-through.
REQ-025 Latency: a capture on cycle N SHALL make rd_valid visible on N+1 when the FIFO was empty.
REQ-026 Full FIFO, capture plus pop in the same cycle: both SHALL occur, level SHALL be unchanged, and no drop SHALL occur.
REQ-027 Full FIFO, capture without pop: the capture SHALL be dropped, overflow SHALL set, and drop_cnt SHALL increment (saturating).
REQ-028 Empty FIFO, capture plus rd_ready: no bypass; the entry SHALL appear next cycle.
REQ-029 Pointers SHALL wrap modulo DEPTH; fifo_level SHALL range 0..DEPTH.
REQ-030 RUN->DRAIN on test_ending=1; a capture in that same cycle SHALL still be accepted.
REQ-031 In DRAIN, captures SHALL be ignored and not counted as drops; pops SHALL continue.
REQ-032 DRAIN->DONE when fifo_level=0 after the cycle's pop.
REQ-033 Any state->DONE on test_has_ended=1; the FIFO SHALL be flushed to empty in the same transition; test_has_ended SHALL take priority over test_ending.
REQ-034 In DONE: done=1, rd_valid=0, captures ignored; DONE SHALL be held until reset.

Reset
REQ-035 Reset SHALL clear: rd_valid=0, rd_data=0, rd_count=0, fifo_level=0, overflow=0, count_err=0, drop_cnt=0, done=0, pointers=0, state=RUN.
REQ-036 Reset asserted mid-operation SHALL take priority over every other input in that cycle.

Structure
REQ-037 Package lab5_nios2_qsys_0_oci_pkg SHALL hold the FSM state encoding (RUN=2'd0, DRAIN=2'd1, DONE=2'd2) and the default parameter constants.
REQ-038 Storage SHALL be the sub-module lab5_nios2_qsys_0_oci_dct_fifo (parametrised width and depth, push/pop/flush, level); the FSM and flags SHALL be in the top.

Verification
REQ-039 Defaults; three loads with counts 5, 15, 1 and rd_ready=1 -> three reads in order, rd_count 5, 15, 1, each one cycle after load.
REQ-040 rd_ready=0; 10 loads -> fifo_level=8, overflow=1, drop_cnt=2; then with a load and pop in the same cycle at full -> drop_cnt stays 2.
REQ-041 Load with dct_count=4'd15 then 4'd0 at SLOTS=12 (CNT_W=4) -> one entry with rd_count=12, count_err=1; the zero-count load is ignored.
REQ-042 4 entries queued, test_ending plus a load in the same cycle -> 5 entries drained, done=1 on the cycle after the last pop, later loads ignored.
REQ-043 3 entries queued, test_ending and test_has_ended together -> next cycle done=1, rd_valid=0, fifo_level=0.
REQ-044 Reset asserted in DONE with overflow=1 -> all outputs at their reset values next cycle, state RUN, new capture accepted.
